sha3_state_serializer: RTL and testbench

SHA3_STATE_SERIALIZER -- requirements
Module: sha3_state_serializer

---
 rtl/sha3_pkg.sv | 15 +
 rtl/sha3_lane_select.sv | 28 ++
 rtl/sha3_state_serializer.sv | 117 +++++++++++
 tb/tb_sha3_state_serializer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 datapath blocks.
//   lane_t     : one 64-bit Keccak lane
//   row_t      : one row of five lanes, element [x] is lane x of that row
//   lane_idx_t : lane index L = x + 5*y (0..24)
package sha3_pkg;

  localparam int LANE_WIDTH      = 64;
  localparam int LANES_PER_STATE = 25;
  localparam int ROW_WIDTH       = 5;

  typedef logic [LANE_WIDTH-1:0] lane_t;
  typedef lane_t [ROW_WIDTH-1:0] row_t;
  typedef logic [4:0]            lane_idx_t;

endpackage

// File: rtl/sha3_lane_select.sv
// Combinational lane picker for the two-slot state store.
//   slot0, slot1 : packed slot contents, lane n at bits [n*64 +: 64]
//   slot_sel     : which slot is read
//   lane_idx     : lane index within the slot (0..OUTPUT_LANES-1)
//   lane         : selected lane, zero for an out-of-range index
module sha3_lane_select
  import sha3_pkg::*;
#(
  parameter int OUTPUT_LANES = 25
) (
  input  logic [OUTPUT_LANES*LANE_WIDTH-1:0] slot0,
  input  logic [OUTPUT_LANES*LANE_WIDTH-1:0] slot1,
  input  logic                               slot_sel,
  input  lane_idx_t                          lane_idx,
  output lane_t                              lane
);

  always_comb begin
    lane = '0;
    for (int i = 0; i < OUTPUT_LANES; i++) begin
      if (lane_idx == i[4:0]) begin
        lane = slot_sel ? slot1[i*LANE_WIDTH +: LANE_WIDTH]
                        : slot0[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

endmodule

// File: rtl/sha3_state_serializer.sv
// Captures 5x5 Keccak states from the round pipeline into a two-slot
// ping-pong FIFO and emits the first OUTPUT_LANES lanes of each state one
// lane per transfer, in ascending L = x + 5*y.
//   clk, rst               : clock, asynchronous active-high reset
//   isa..ise, sample       : state rows (isa is y=0) and capture strobe; no
//                            backpressure, a sample with no free slot is
//                            dropped and sets the sticky overflow flag
//   odata, ovalid, iready  : lane output handshake
//   olast                  : marks lane OUTPUT_LANES-1 of a state
//   pending                : captured states not yet fully emitted (0..2)
//   overflow               : sticky dropped-sample flag
//
// Handshake: a lane transfers on a rising edge where ovalid && iready.
// While ovalid is high and iready is low, odata/olast/ovalid hold. ovalid
// never drops without a transfer; odata is zero whenever ovalid is low.
module sha3_state_serializer
  import sha3_pkg::*;
#(
  parameter int OUTPUT_LANES = 25,
  parameter     ROW_ORDER    = "abcde"
) (
  input  logic       clk,
  input  logic       rst,
  input  row_t       isa,
  input  row_t       isb,
  input  row_t       isc,
  input  row_t       isd,
  input  row_t       ise,
  input  logic       sample,
  output lane_t      odata,
  output logic       ovalid,
  input  logic       iready,
  output logic       olast,
  output logic [1:0] pending,
  output logic       overflow
);

  localparam int        SLOT_W    = OUTPUT_LANES * LANE_WIDTH;
  localparam lane_idx_t LAST_LANE = lane_idx_t'(OUTPUT_LANES - 1);

  if (OUTPUT_LANES < 1 || OUTPUT_LANES > LANES_PER_STATE) begin : g_bad_lanes
    $error("sha3_state_serializer: OUTPUT_LANES out of range 1..25");
  end
  if (ROW_ORDER != "abcde") begin : g_bad_order
    $error("sha3_state_serializer: unsupported ROW_ORDER");
  end

  // Lane L sits at bits [L*64 +: 64] because isa[0] lands in the LSBs.
  logic [LANES_PER_STATE*LANE_WIDTH-1:0] state_flat;
  assign state_flat = {ise, isd, isc, isb, isa};

  logic [SLOT_W-1:0] slot0, slot1;
  logic [1:0]        full, full_nxt;
  logic              rd_ptr, wr_ptr;
  lane_idx_t         lane_cnt;
  logic              overflow_q;
  lane_t             sel_lane;

  logic cur_valid, xfer, last_xfer, both_full, capture, drop;

  always_comb begin
    cur_valid = full[rd_ptr];
    xfer      = cur_valid && iready;
    last_xfer = xfer && (lane_cnt == LAST_LANE);
    both_full = &full;
    // A slot being freed by this cycle's final transfer can be refilled at
    // the same edge, so a full FIFO does not drop in that case.
    capture   = sample && (!both_full || last_xfer);
    drop      = sample && both_full && !last_xfer;

    // Clear first, then set: when both pointers name the same slot the
    // new capture must win.
    full_nxt = full;
    if (last_xfer) full_nxt[rd_ptr] = 1'b0;
    if (capture)   full_nxt[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full       <= 2'b00;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      lane_cnt   <= '0;
      overflow_q <= 1'b0;
    end else begin
      full <= full_nxt;
      if (capture)   wr_ptr <= ~wr_ptr;
      if (last_xfer) rd_ptr <= ~rd_ptr;
      if (xfer)      lane_cnt <= last_xfer ? '0 : lane_cnt + 5'd1;
      if (drop)      overflow_q <= 1'b1;
    end
  end

  // Slot contents need no reset: they are only observable through a full
  // flag, which reset clears.
  always_ff @(posedge clk) begin
    if (capture && !wr_ptr) slot0 <= state_flat[SLOT_W-1:0];
    if (capture &&  wr_ptr) slot1 <= state_flat[SLOT_W-1:0];
  end

  sha3_lane_select #(
    .OUTPUT_LANES(OUTPUT_LANES)
  ) u_lane_select (
    .slot0   (slot0),
    .slot1   (slot1),
    .slot_sel(rd_ptr),
    .lane_idx(lane_cnt),
    .lane    (sel_lane)
  );

  assign ovalid   = cur_valid;
  assign olast    = cur_valid && (lane_cnt == LAST_LANE);
  assign odata    = cur_valid ? sel_lane : '0;
  assign pending  = {1'b0, full[0]} + {1'b0, full[1]};
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sha3_state_serializer.sv
// Directed bench: three instances (OUTPUT_LANES = 25, 4, 1) share clock,
// reset and row inputs; each has its own sample/iready.
module tb_sha3_state_serializer;
  import sha3_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [LANES_PER_STATE*LANE_WIDTH-1:0] st;
  row_t isa, isb, isc, isd, ise;
  assign isa = st[0*320 +: 320];
  assign isb = st[1*320 +: 320];
  assign isc = st[2*320 +: 320];
  assign isd = st[3*320 +: 320];
  assign ise = st[4*320 +: 320];

  logic s25, r25, ov25, ol25, of25;
  logic s4,  r4,  ov4,  ol4,  of4;
  logic s1,  r1,  ov1,  ol1,  of1;
  lane_t od25, od4, od1;
  logic [1:0] pd25, pd4, pd1;

  sha3_state_serializer #(.OUTPUT_LANES(25)) u_dut25 (
    .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .sample(s25), .odata(od25), .ovalid(ov25), .iready(r25), .olast(ol25),
    .pending(pd25), .overflow(of25));

  sha3_state_serializer #(.OUTPUT_LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .sample(s4), .odata(od4), .ovalid(ov4), .iready(r4), .olast(ol4),
    .pending(pd4), .overflow(of4));

  sha3_state_serializer #(.OUTPUT_LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .sample(s1), .odata(od1), .ovalid(ov1), .iready(r1), .olast(ol1),
    .pending(pd1), .overflow(of1));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_o(input string nm,
                       input logic v, input logic [63:0] d, input logic l, input logic [1:0] p,
                       input logic ev, input logic [63:0] ed, input logic el, input logic [1:0] ep);
    chk({nm, " ovalid"},  64'(v), 64'(ev));
    chk({nm, " odata"},   d, ed);
    chk({nm, " olast"},   64'(l), 64'(el));
    chk({nm, " pending"}, 64'(p), 64'(ep));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_state(input logic [63:0] base);
    for (int n = 0; n < LANES_PER_STATE; n++) st[n*64 +: 64] = base + 64'(n);
  endtask

  typedef struct {
    logic        ready;
    logic        ev;
    logic [63:0] ed;
    logic        el;
    logic [1:0]  ep;
  } vec_t;

  vec_t tbl[8];

  initial begin
    rst = 1'b1;
    s25 = 0; r25 = 0; s4 = 0; r4 = 0; s1 = 0; r1 = 0;
    st = '0;

    tbl[0] = '{1'b1, 1'b1, 64'h4000, 1'b0, 2'd1};
    tbl[1] = '{1'b0, 1'b1, 64'h4001, 1'b0, 2'd1};
    tbl[2] = '{1'b1, 1'b1, 64'h4001, 1'b0, 2'd1};
    tbl[3] = '{1'b0, 1'b1, 64'h4002, 1'b0, 2'd1};
    tbl[4] = '{1'b1, 1'b1, 64'h4002, 1'b0, 2'd1};
    tbl[5] = '{1'b0, 1'b1, 64'h4003, 1'b1, 2'd1};
    tbl[6] = '{1'b1, 1'b1, 64'h4003, 1'b1, 2'd1};
    tbl[7] = '{1'b0, 1'b0, 64'h0,    1'b0, 2'd0};

    // Reset state
    step(); step();
    chk_o("reset", ov25, od25, ol25, pd25, 1'b0, 64'h0, 1'b0, 2'd0);
    chk("reset overflow", 64'(of25), 64'd0);
    rst = 1'b0;

    // Single state, full 25 lanes, iready held high
    set_state(64'h1000); s25 = 1; r25 = 1;
    step();
    s25 = 0;
    for (int n = 0; n < 25; n++) begin
      chk_o("full25 lane", ov25, od25, ol25, pd25, 1'b1, 64'h1000 + 64'(n), n == 24, 2'd1);
      step();
    end
    chk_o("full25 end", ov25, od25, ol25, pd25, 1'b0, 64'h0, 1'b0, 2'd0);

    // OUTPUT_LANES=4 with toggling iready, table driven
    set_state(64'h4000); s4 = 1;
    step();
    s4 = 0;
    for (int k = 0; k < 8; k++) begin
      chk_o($sformatf("lanes4 vec%0d", k), ov4, od4, ol4, pd4,
            tbl[k].ev, tbl[k].ed, tbl[k].el, tbl[k].ep);
      r4 = tbl[k].ready;
      step();
    end

    // OUTPUT_LANES=1, back-to-back samples
    r1 = 1;
    set_state(64'h7700); s1 = 1;
    step();
    chk_o("lanes1 s0", ov1, od1, ol1, pd1, 1'b1, 64'h7700, 1'b1, 2'd1);
    set_state(64'h7800);
    step();
    chk_o("lanes1 s1", ov1, od1, ol1, pd1, 1'b1, 64'h7800, 1'b1, 2'd1);
    set_state(64'h7900);
    step();
    chk_o("lanes1 s2", ov1, od1, ol1, pd1, 1'b1, 64'h7900, 1'b1, 2'd1);
    s1 = 0;
    step();
    chk_o("lanes1 end", ov1, od1, ol1, pd1, 1'b0, 64'h0, 1'b0, 2'd0);
    chk("lanes1 overflow", 64'(of1), 64'd0);

    // Three samples while stalled: C dropped, A then B without a gap
    r25 = 0;
    set_state(64'h0A00); s25 = 1; step();
    set_state(64'h0B00); step();
    set_state(64'h0C00); step();
    s25 = 0;
    chk("ovf flag", 64'(of25), 64'd1);
    chk_o("ovf stall", ov25, od25, ol25, pd25, 1'b1, 64'h0A00, 1'b0, 2'd2);
    step();
    chk_o("ovf stall hold", ov25, od25, ol25, pd25, 1'b1, 64'h0A00, 1'b0, 2'd2);
    r25 = 1;
    for (int n = 0; n < 25; n++) begin
      chk_o("ovf A", ov25, od25, ol25, pd25, 1'b1, 64'h0A00 + 64'(n), n == 24, 2'd2);
      step();
    end
    for (int n = 0; n < 25; n++) begin
      chk_o("ovf B", ov25, od25, ol25, pd25, 1'b1, 64'h0B00 + 64'(n), n == 24, 2'd1);
      step();
    end
    chk_o("ovf end", ov25, od25, ol25, pd25, 1'b0, 64'h0, 1'b0, 2'd0);
    chk("ovf sticky", 64'(of25), 64'd1);

    rst = 1; step();
    chk("ovf cleared by reset", 64'(of25), 64'd0);
    rst = 0;

    // Full FIFO, sample D coincident with A's final transfer
    r25 = 0;
    set_state(64'h1A00); s25 = 1; step();
    set_state(64'h1B00); step();
    s25 = 0; r25 = 1;
    for (int n = 0; n < 24; n++) begin
      chk_o("swap A", ov25, od25, ol25, pd25, 1'b1, 64'h1A00 + 64'(n), 1'b0, 2'd2);
      step();
    end
    chk_o("swap A last", ov25, od25, ol25, pd25, 1'b1, 64'h1A18, 1'b1, 2'd2);
    set_state(64'h1D00); s25 = 1;
    step();
    s25 = 0;
    chk("swap no overflow", 64'(of25), 64'd0);
    for (int n = 0; n < 25; n++) begin
      chk_o("swap B", ov25, od25, ol25, pd25, 1'b1, 64'h1B00 + 64'(n), n == 24, 2'd2);
      step();
    end
    for (int n = 0; n < 25; n++) begin
      chk_o("swap D", ov25, od25, ol25, pd25, 1'b1, 64'h1D00 + 64'(n), n == 24, 2'd1);
      step();
    end
    chk_o("swap end", ov25, od25, ol25, pd25, 1'b0, 64'h0, 1'b0, 2'd0);
    chk("swap overflow end", 64'(of25), 64'd0);

    // Reset in the middle of emission
    set_state(64'h5500); s25 = 1; step();
    s25 = 0;
    for (int n = 0; n < 10; n++) step();
    chk_o("midrst lane10", ov25, od25, ol25, pd25, 1'b1, 64'h550A, 1'b0, 2'd1);
    rst = 1;
    #1;
    chk_o("midrst async", ov25, od25, ol25, pd25, 1'b0, 64'h0, 1'b0, 2'd0);
    step();
    chk_o("midrst held", ov25, od25, ol25, pd25, 1'b0, 64'h0, 1'b0, 2'd0);
    rst = 0;
    set_state(64'hAAAA_0000); s25 = 1;
    step();
    s25 = 0;
    for (int n = 0; n < 25; n++) begin
      chk_o("postrst lane", ov25, od25, ol25, pd25, 1'b1, 64'hAAAA_0000 + 64'(n), n == 24, 2'd1);
      step();
    end
    chk_o("postrst end", ov25, od25, ol25, pd25, 1'b0, 64'h0, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
